// File: rtl/cic_comp_pkg.sv
// Shared types, default compensation coefficients and saturation helpers
// for the CIC compensation FIR.
package cic_comp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2
  } state_t;

  localparam int COEF_TAPS = 15;
  localparam int COEF_W    = 18;

  // Symmetric droop-compensation taps; they sum to 65536 for unity DC gain at 16 fractional bits.
  localparam logic signed [COEF_W-1:0] CIC_COMP_COEF_DEFAULT [COEF_TAPS] = '{
    -18'sd202,  18'sd301, -18'sd598,  18'sd1003, -18'sd1800,  18'sd3206, -18'sd7010,
     18'sd75736,
    -18'sd7010, 18'sd3206, -18'sd1800, 18'sd1003, -18'sd598,  18'sd301, -18'sd202
  };

  function automatic longint sat_hi(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/cic_comp_sat.sv
// Combinational round-half-up, arithmetic shift and saturation from the
// accumulator width down to the output width.
module cic_comp_sat import cic_comp_pkg::*; #(
  parameter int ACC_W = 38,
  parameter int FRAC  = 16,
  parameter int OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] y
);

  localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(1) <<< (FRAC - 1);

  logic signed [ACC_W:0] rnd_s;
  logic signed [ACC_W:0] shr_s;
  longint                shr_l_s;

  // Round, shift and clamp to the signed output range.
  always_comb begin
    rnd_s   = $signed({acc[ACC_W-1], acc}) + HALF;
    shr_s   = rnd_s >>> FRAC;
    shr_l_s = longint'(shr_s);
    if (shr_l_s > sat_hi(OUT_W)) begin
      y = OUT_W'(sat_hi(OUT_W));
    end else if (shr_l_s < sat_lo(OUT_W)) begin
      y = OUT_W'(sat_lo(OUT_W));
    end else begin
      y = OUT_W'(shr_l_s);
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR with one shared multiplier, one tap per clock.
// Optional coefficient loading is enabled by defining CIC_COMP_COEF_LOAD_EN.
module cic_comp_fir import cic_comp_pkg::*; #(
  parameter int NUM_TAPS        = 15,
  parameter int NUM_BITS_INPUT  = 16,
  parameter int NUM_BITS_COEF   = 18,
  parameter int COEF_FRAC_BITS  = 16,
  parameter int NUM_BITS_OUTPUT = 16
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic                              tick_i,
  input  logic signed [NUM_BITS_INPUT-1:0]  signal_i,
`ifdef CIC_COMP_COEF_LOAD_EN
  input  logic                              coef_we_i,
  input  logic [$clog2(NUM_TAPS)-1:0]       coef_addr_i,
  input  logic signed [NUM_BITS_COEF-1:0]   coef_data_i,
`endif
  output logic signed [NUM_BITS_OUTPUT-1:0] signal_o,
  output logic                              tick_o,
  output logic                              busy_o,
  output logic                              overrun_o
);

  localparam int PTR_W  = $clog2(NUM_TAPS);
  localparam int PROD_W = NUM_BITS_INPUT + NUM_BITS_COEF;
  localparam int ACC_W  = PROD_W + $clog2(NUM_TAPS);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_TAPS - 1);

  state_t                              state_r, state_s;
  logic signed [NUM_BITS_INPUT-1:0]    dline_r [NUM_TAPS];
  logic [PTR_W-1:0]                    wr_ptr_r, rd_ptr_r, k_r;
  logic signed [ACC_W-1:0]             acc_r;
  logic signed [NUM_BITS_COEF-1:0]     coef_s;
  logic signed [PROD_W-1:0]            prod_s;
  logic signed [NUM_BITS_OUTPUT-1:0]   sat_y_s;
  logic                                accept_s;

  // A sample coinciding with the result strobe is rejected like any busy-time tick.
  assign accept_s = tick_i && (state_r == IDLE) && !tick_o;
  assign prod_s   = PROD_W'(dline_r[rd_ptr_r]) * PROD_W'(coef_s);

`ifdef CIC_COMP_COEF_LOAD_EN
  logic signed [NUM_BITS_COEF-1:0] coef_r [NUM_TAPS];
  logic                            pend_v_r;
  logic [PTR_W-1:0]                pend_addr_r;
  logic signed [NUM_BITS_COEF-1:0] pend_data_r;

  assign coef_s = coef_r[k_r];

  // Coefficient file; writes during a computation wait for the next idle cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NUM_TAPS; i++) coef_r[i] <= NUM_BITS_COEF'(CIC_COMP_COEF_DEFAULT[i]);
      pend_v_r    <= 1'b0;
      pend_addr_r <= '0;
      pend_data_r <= '0;
    end else if (busy_o) begin
      if (coef_we_i && (coef_addr_i <= LAST)) begin
        pend_v_r    <= 1'b1;
        pend_addr_r <= coef_addr_i;
        pend_data_r <= coef_data_i;
      end
    end else begin
      if (pend_v_r) begin
        coef_r[pend_addr_r] <= pend_data_r;
        pend_v_r            <= 1'b0;
      end
      if (coef_we_i && (coef_addr_i <= LAST)) coef_r[coef_addr_i] <= coef_data_i;
    end
  end
`else
  assign coef_s = NUM_BITS_COEF'(CIC_COMP_COEF_DEFAULT[k_r]);
`endif

  cic_comp_sat #(
    .ACC_W (ACC_W),
    .FRAC  (COEF_FRAC_BITS),
    .OUT_W (NUM_BITS_OUTPUT)
  ) u_sat (
    .acc (acc_r),
    .y   (sat_y_s)
  );

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_r <= IDLE;
    else           state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = MAC; else state_s = IDLE;
      MAC:     if (k_r == LAST) state_s = ROUND; else state_s = MAC;
      ROUND:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Delay line write, newest-first read walk and accumulation.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < NUM_TAPS; i++) dline_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      k_r      <= '0;
      acc_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            dline_r[wr_ptr_r] <= signal_i;
            wr_ptr_r          <= (wr_ptr_r == LAST) ? '0 : wr_ptr_r + PTR_W'(1);
            rd_ptr_r          <= wr_ptr_r;
            k_r               <= '0;
            acc_r             <= '0;
          end
        end
        MAC: begin
          acc_r    <= acc_r + ACC_W'(prod_s);
          rd_ptr_r <= (rd_ptr_r == '0) ? LAST : rd_ptr_r - PTR_W'(1);
          k_r      <= k_r + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; overrun is sticky until reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      signal_o  <= '0;
      tick_o    <= 1'b0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      tick_o <= (state_r == ROUND);
      busy_o <= (state_s != IDLE);
      if (state_r == ROUND) signal_o <= sat_y_s;
      if (tick_i && !accept_s) overrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench: a convolution model checks both DUT instances every
// cycle, with directed literal checks for impulse, DC, latency and saturation.
module tb_cic_comp_fir;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick0 = 1'b0, tick1 = 1'b0;
  logic signed [15:0] sig0 = '0, sig1 = '0;
  logic signed [15:0] y0, y1;
  logic to0, to1, b0, b1, o0, o1;

  int n_cmp = 0;
  int n_bad = 0;
  longint n = 0;

  longint coef [15] = '{-202, 301, -598, 1003, -1800, 3206, -7010, 75736,
                        -7010, 3206, -1800, 1003, -598, 301, -202};
  longint imp_exp [16] = '{-50, 75, -149, 251, -450, 802, -1752, 18934,
                           -1752, 802, -450, 251, -149, 75, -50, 0};
  int     frac [2] = '{16, 14};
  longint hist [2][15];
  longint due [2], last_acc [2], pend [2], held [2];
  bit     ovr [2];
  longint out0 [$];
  longint out1 [$];

  always #5 clk = ~clk;

  cic_comp_fir dut (
    .clk_i(clk), .reset_ni(rst_n), .tick_i(tick0), .signal_i(sig0),
`ifdef CIC_COMP_COEF_LOAD_EN
    .coef_we_i(1'b0), .coef_addr_i(4'd0), .coef_data_i(18'sd0),
`endif
    .signal_o(y0), .tick_o(to0), .busy_o(b0), .overrun_o(o0)
  );

  cic_comp_fir #(.COEF_FRAC_BITS(14)) dut_sat (
    .clk_i(clk), .reset_ni(rst_n), .tick_i(tick1), .signal_i(sig1),
`ifdef CIC_COMP_COEF_LOAD_EN
    .coef_we_i(1'b0), .coef_addr_i(4'd0), .coef_data_i(18'sd0),
`endif
    .signal_o(y1), .tick_o(to1), .busy_o(b1), .overrun_o(o1)
  );

  task automatic chk(input string name, input int idx, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at cycle %0d: got %0d, expected %0d", name, idx, n, act, exp);
    end
  endtask

  function automatic longint fir(input int id);
    longint s = 0;
    for (int k = 0; k < 15; k++) s += hist[id][k] * coef[k];
    s = (s + (64'sd1 <<< (frac[id] - 1))) >>> frac[id];
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic check_dut(input int id, input logic tk, input logic signed [15:0] si,
                           input logic signed [15:0] y, input logic to, input logic b,
                           input logic o);
    bit etick, ebusy;
    if (!rst_n) begin
      chk("rst_signal_o", id, y, 0);
      chk("rst_tick_o", id, to, 0);
      chk("rst_busy_o", id, b, 0);
      chk("rst_overrun_o", id, o, 0);
      for (int k = 0; k < 15; k++) hist[id][k] = 0;
      due[id] = -1; last_acc[id] = -100; pend[id] = 0; held[id] = 0; ovr[id] = 1'b0;
    end else begin
      etick = (due[id] == n);
      if (etick) held[id] = pend[id];
      ebusy = (n > last_acc[id]) && (n <= last_acc[id] + 16);
      chk("tick_o", id, to, etick);
      chk("busy_o", id, b, ebusy);
      chk("overrun_o", id, o, ovr[id]);
      chk("signal_o", id, y, held[id]);
      if (to) begin
        if (id == 0) out0.push_back(y);
        else out1.push_back(y);
      end
      if (tk) begin
        if (ebusy || etick) begin
          ovr[id] = 1'b1;
        end else begin
          for (int k = 14; k > 0; k--) hist[id][k] = hist[id][k-1];
          hist[id][0] = si;
          pend[id] = fir(id);
          due[id] = n + 17;
          last_acc[id] = n;
        end
      end
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check_dut(0, tick0, sig0, y0, to0, b0, o0);
      check_dut(1, tick1, sig1, y1, to1, b1, o1);
      n++;
    end
  end

  task automatic send(input int id, input logic signed [15:0] v);
    @(posedge clk); #1;
    if (id == 0) begin tick0 = 1'b1; sig0 = v; end
    else begin tick1 = 1'b1; sig1 = v; end
    @(posedge clk); #1;
    tick0 = 1'b0; tick1 = 1'b0;
    repeat (18) @(posedge clk);
  endtask

  initial begin
    int first, nb;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Impulse: the coefficient set scaled by 1/4, then zero.
    out0.delete();
    send(0, 16'sd16384);
    for (int i = 0; i < 15; i++) send(0, 16'sd0);
    chk("imp_count", 0, out0.size(), 16);
    for (int k = 0; k < 16; k++) chk("impulse", k, (k < out0.size()) ? out0[k] : -99999, imp_exp[k]);

    // DC unity gain.
    out0.delete();
    for (int i = 0; i < 16; i++) send(0, 16'sd1000);
    chk("dc_count", 0, out0.size(), 16);
    for (int k = 14; k < 16; k++) chk("dc", k, (k < out0.size()) ? out0[k] : -99999, 1000);
    chk("dc_overrun", 0, o0, 0);

    // Latency and busy window.
    first = -1; nb = 0;
    @(posedge clk); #1; tick0 = 1'b1; sig0 = 16'sd123;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (to0 && first < 0) first = i;
      if (b0) nb++;
      @(posedge clk); #1; tick0 = 1'b0;
    end
    chk("latency", 0, first, 17);
    chk("busy_cycles", 0, nb, 16);

    // Overrun: second tick five cycles later is dropped.
    @(posedge clk); #1; tick0 = 1'b1; sig0 = 16'sd700;
    @(posedge clk); #1; tick0 = 1'b0;
    repeat (4) @(posedge clk);
    #1; tick0 = 1'b1; sig0 = 16'sd5000;
    @(posedge clk); #1; tick0 = 1'b0;
    repeat (20) @(posedge clk);
    chk("overrun_sticky", 0, o0, 1);
    for (int i = 0; i < 3; i++) send(0, 16'sd0);

    // Reset in the middle of a computation.
    @(posedge clk); #1; tick0 = 1'b1; sig0 = 16'sd16384;
    @(posedge clk); #1; tick0 = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("reset_overrun", 0, o0, 0);
    out0.delete();
    send(0, 16'sd16384);
    chk("post_reset_count", 0, out0.size(), 1);
    chk("post_reset_first", 0, (out0.size() > 0) ? out0[0] : -99999, -50);

    // Saturation with 14 fractional bits.
    out1.delete();
    for (int i = 0; i < 15; i++) send(1, 16'sd20000);
    chk("sat_hi", 1, (out1.size() == 15) ? out1[14] : -99999, 32767);
    out1.delete();
    for (int i = 0; i < 15; i++) send(1, -16'sd20000);
    chk("sat_lo", 1, (out1.size() == 15) ? out1[14] : -99999, -32768);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
